// File: rtl/multiplier_module.sv
// Sequential shift-and-add unsigned multiplier: BITS iterations per product,
// start/busy/ready handshake, registered 2*BITS-wide product.
module multiplier_module #(
  parameter int BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [BITS-1:0]     multiplicand,
  input  logic [BITS-1:0]     multiplier,
  output logic [2*BITS-1:0]   product,
  output logic [BITS-1:0]     result,
  output logic                overflow,
  output logic                busy,
  output logic                ready
);

  localparam int CW = $clog2(BITS) + 1;
  localparam logic [CW-1:0] LAST = CW'(BITS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [BITS-1:0]     r_mcand;
  logic [BITS-1:0]     r_mplr;
  logic [2*BITS-1:0]   r_acc;
  logic [2*BITS-1:0]   r_product;
  logic [CW-1:0]       r_count;
  logic [BITS:0]       w_sum;
  logic [2*BITS-1:0]   w_acc_next;
  logic                w_launch;
  logic                w_last;

  // start is honoured only outside RUN, so a request mid-operation is dropped
  assign w_launch = start && (r_state != RUN);
  assign w_last   = (r_state == RUN) && (r_count == LAST);

  // carry out of the high-half add becomes the new MSB after the shift
  assign w_sum      = {1'b0, r_acc[2*BITS-1:BITS]} + (r_mplr[0] ? {1'b0, r_mcand} : '0);
  assign w_acc_next = {w_sum, r_acc[BITS-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    if (start) w_next = RUN;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy  = (r_state == RUN);
    ready = (r_state == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mcand   <= '0;
      r_mplr    <= '0;
      r_acc     <= '0;
      r_count   <= '0;
      r_product <= '0;
    end else if (w_launch) begin
      r_mcand <= multiplicand;
      r_mplr  <= multiplier;
      r_acc   <= '0;
      r_count <= '0;
    end else if (r_state == RUN) begin
      r_acc   <= w_acc_next;
      r_mplr  <= r_mplr >> 1;
      r_count <= r_count + CW'(1);
      if (w_last) begin
        r_product <= w_acc_next;
      end
    end
  end

  assign product  = r_product;
  assign result   = r_product[BITS-1:0];
  assign overflow = |r_product[2*BITS-1:BITS];

endmodule

// File: tb/tb_multiplier_module.sv
// Randomized self-checking bench for multiplier_module; expected products
// come from plain integer multiplication of the applied operands.
module tb_multiplier_module;

  localparam int BITS = 16;

  logic              clk;
  logic              reset;
  logic              start;
  logic [BITS-1:0]   mcand;
  logic [BITS-1:0]   mplr;
  logic [2*BITS-1:0] product;
  logic [BITS-1:0]   result;
  logic              overflow;
  logic              busy;
  logic              ready;

  int n_chk;
  int n_pass;

  multiplier_module #(.BITS(BITS)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (mcand),
    .multiplier   (mplr),
    .product      (product),
    .result       (result),
    .overflow     (overflow),
    .busy         (busy),
    .ready        (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [2*BITS-1:0] ref_mul(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    return p[2*BITS-1:0];
  endfunction

  // One operation; optionally pulses a second start at iteration pulse_at.
  task automatic run_op(input logic [BITS-1:0] a, input logic [BITS-1:0] b, input int pulse_at);
    logic [2*BITS-1:0] exp;
    logic [2*BITS-1:0] prev;
    int bad;
    exp = ref_mul(a, b);
    bad = 0;
    @(negedge clk);
    prev  = product;
    start = 1'b1;
    mcand = a;
    mplr  = b;
    @(negedge clk);
    start = 1'b0;
    mcand = 16'($urandom);
    mplr  = 16'($urandom);
    for (int k = 0; k < BITS; k++) begin
      if (!busy || ready || product !== prev) bad++;
      if (k == pulse_at) begin
        start = 1'b1;
        mcand = 16'd2;
        mplr  = 16'd2;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("run_window_errors", 64'(bad), 64'd0);
    chk("done_ready", 64'(ready), 64'd1);
    chk("done_busy", 64'(busy), 64'd0);
    chk("product", 64'(product), 64'(exp));
    chk("result", 64'(result), 64'(exp[BITS-1:0]));
    chk("overflow", 64'(overflow), 64'(|exp[2*BITS-1:BITS]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [BITS-1:0]   a;
    logic [BITS-1:0]   b;
    logic [2*BITS-1:0] exp;
    int n;
    n_chk  = 0;
    n_pass = 0;
    reset  = 1'b1;
    start  = 1'b0;
    mcand  = '0;
    mplr   = '0;
    repeat (2) @(negedge clk);
    chk("rst_product", 64'(product), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(ready), 64'd0);
    reset = 1'b0;

    run_op(16'd3, 16'd5, -1);
    run_op(16'hFFFF, 16'hFFFF, -1);
    run_op(16'h0000, 16'h1234, -1);
    run_op(16'h1234, 16'h0001, -1);
    run_op(16'd7, 16'd9, 5);

    // asynchronous abort mid-operation
    @(negedge clk);
    start = 1'b1;
    mcand = 16'd100;
    mplr  = 16'd200;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_product", 64'(product), 64'd0);
    chk("abort_result", 64'(result), 64'd0);
    chk("abort_overflow", 64'(overflow), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_ready", 64'(ready), 64'd0);
    @(negedge clk);
    chk("abort_idle_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    run_op(16'd100, 16'd200, -1);

    // start held high: back-to-back operations
    start = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      case (i)
        0:       begin a = 16'h8000; b = 16'h0002; end
        1:       begin a = 16'hFFFF; b = 16'hFFFF; end
        2:       begin a = 16'h0000; b = 16'hFFFF; end
        3:       begin a = 16'hFFFF; b = 16'h0001; end
        default: begin a = 16'($urandom); b = 16'($urandom); end
      endcase
      exp   = ref_mul(a, b);
      mcand = a;
      mplr  = b;
      n = 0;
      while (!busy && n < 4) begin
        @(negedge clk);
        n++;
      end
      chk("b2b_gap", 64'(n), 64'd1);
      mcand = 16'($urandom);
      mplr  = 16'($urandom);
      n = 0;
      while (!ready && n < BITS + 4) begin
        @(negedge clk);
        n++;
      end
      chk("b2b_latency", 64'(n), 64'(BITS));
      chk("b2b_product", 64'(product), 64'(exp));
      chk("b2b_result", 64'(result), 64'(exp[BITS-1:0]));
      chk("b2b_overflow", 64'(overflow), 64'(|exp[2*BITS-1:BITS]));
    end
    start = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
